timer: RTL
==========

TIMER -- requirements
Module: timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hFF04; the byte address of DIV, with TIMA, TMA and TAC at BASE_ADDR+1, +2 and +3.
REQ-002 SHALL have port clk, input, 1 bit; 4 MHz system clock, one T-cycle per edge.
REQ-003 SHALL have port reset, input, 1 bit; reset, synchronous, active-high.
REQ-004 SHALL have port t_cycle, input, 2 bits; the bus initiator's T-cycle phase, 0..3.
REQ-005 SHALL have port mem_addr, input, 16 bits; the bus address.
REQ-006 SHALL have port mem_enable, input, 1 bit; bus access valid.
REQ-007 SHALL have port mem_write, input, 1 bit; 1 = write, 0 = read.
REQ-008 SHALL have port mem_wdata, input, 8 bits; write data from the initiator.
REQ-009 SHALL have port mem_rdata, output, 8 bits; read data to the initiator.
REQ-010 SHALL have port mem_hit, output, 1 bit; the address decodes to this block.
REQ-011 SHALL have port irq_timer, output, 1 bit; timer interrupt request, a 1-clk pulse.

Function
REQ-012 SHALL hold a 16-bit internal counter DIVC that increments by 1 every clk and wraps from FFFF to 0000.
REQ-013 SHALL assert mem_hit combinationally when mem_enable=1 and mem_addr is in BASE_ADDR..BASE_ADDR+3.
REQ-014 SHALL drive mem_rdata combinationally: DIV = DIVC[15:8]; TIMA; TMA; TAC = {5'b11111, TAC[2:0]}; 8'hFF when mem_hit=0.
REQ-015 SHALL commit writes only on the clk edge where t_cycle=3, mem_hit=1 and mem_write=1; reads have no side effects.
REQ-016 SHALL clear DIVC to 0000 on any DIV write, regardless of the data value.
REQ-017 SHALL select the tap bit by TAC[1:0]: 00 selects DIVC[9], 01 selects DIVC[3], 10 selects DIVC[5], 11 selects DIVC[7].
REQ-018 SHALL form tick = TAC[2] & DIVC[tap] from registered state, register it as tick_d, and generate an increment event when tick_d=1 and tick=0.
REQ-019 SHALL treat falling edges caused by a DIV write or a TAC write (enable or select change) as increment events, per REQ-018.
REQ-020 SHALL implement a state machine with states RUN, OVF and RELOAD, plus a 2-bit delay counter.
REQ-021 In RUN, an increment event SHALL set TIMA to TIMA+1; when TIMA=FF, TIMA SHALL become 00 and the state SHALL move to OVF with the delay counter at 3.
REQ-022 In RUN, a TIMA write on the same edge as an increment event SHALL win: TIMA = mem_wdata and there is no overflow.
REQ-023 OVF SHALL last 4 clks, during which TIMA reads 00 and increment events are dropped.
REQ-024 A TIMA write during OVF SHALL load mem_wdata, cancel the reload, and return the state to RUN with no irq.
REQ-025 At the end of OVF, the block SHALL load TIMA with TMA, pulse irq_timer high for exactly 1 clk, and enter RELOAD with the delay counter at 3.
REQ-026 RELOAD SHALL last 4 clks: TIMA writes are ignored; a TMA write updates both TMA and TIMA; increment events are dropped; the state then returns to RUN.
REQ-027 SHALL write TMA with mem_wdata in any state.
REQ-028 SHALL write TAC[2:0] with mem_wdata[2:0]; bits 7:3 are not stored.
REQ-029 SHALL hold irq_timer at 0 except as specified in REQ-025.

Reset
REQ-030 On reset, DIVC=0000, TIMA=00, TMA=00, TAC=000, tick_d=0, state=RUN, delay=0, irq_timer=0.
REQ-031 Reset SHALL take priority over every write and increment on the same edge; asserting reset during OVF or RELOAD SHALL abandon it with no irq.
REQ-032 Out of reset, mem_rdata SHALL be FF when not selected; DIV, TIMA and TMA read 00 and TAC reads F8.

Verification
REQ-033 The bench SHALL cover: TAC=05, TIMA=00, run 64 clks -> TIMA=04; the DIV read advances by 1 every 256 clks.
REQ-034 The bench SHALL cover: TMA=A0, TAC=05, TIMA=FF, then the next increment -> TIMA=00 for 4 clks, then TIMA=A0 with irq_timer high for exactly 1 clk.
REQ-035 The bench SHALL cover: the same overflow as REQ-034 plus a TIMA write of 33 during OVF -> TIMA=33, no irq, no reload.
REQ-036 The bench SHALL cover: a TIMA write of 55 and a TMA write of 77 during RELOAD -> TIMA=77, TMA=77.
REQ-037 The bench SHALL cover: TAC=04 with DIVC[9]=1, then a DIV write -> TIMA increments by 1 and DIV reads 00.
REQ-038 The bench SHALL cover: a write to TAC with t_cycle other than 3, or to address FF08 -> no register change; a read of FF08 returns FF with mem_hit=0.

Source files
------------

// File: rtl/timer.sv
// Programmable timer with DIV/TIMA/TMA/TAC registers on a byte bus.
// TIMA overflow runs through a 4-clk OVF window and a 4-clk RELOAD window.
module timer #(
   parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  t_cycle,
   input  logic [15:0] mem_addr,
   input  logic        mem_enable,
   input  logic        mem_write,
   input  logic [7:0]  mem_wdata,
   output logic [7:0]  mem_rdata,
   output logic        mem_hit,
   output logic        irq_timer
);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_OVF    = 2'd1;
   localparam logic [1:0] ST_RELOAD = 2'd2;

   localparam logic [1:0] OFS_DIV  = 2'd0;
   localparam logic [1:0] OFS_TIMA = 2'd1;
   localparam logic [1:0] OFS_TMA  = 2'd2;
   localparam logic [1:0] OFS_TAC  = 2'd3;

   logic [15:0] divc_q, divc_d;
   logic [7:0]  tima_q, tima_d;
   logic [7:0]  tma_q,  tma_d;
   logic [2:0]  tac_q,  tac_d;
   logic        tick_q;
   logic [1:0]  state_q, state_d;
   logic [1:0]  dly_q,   dly_d;
   logic        irq_q,   irq_d;

   logic [15:0] offset;
   logic        commit;
   logic        wr_div, wr_tima, wr_tma, wr_tac;
   logic        tap_bit;
   logic        tick;
   logic        inc_evt;

   // Subtracting the base lets the window wrap cleanly for any BASE_ADDR.
   assign offset  = mem_addr - BASE_ADDR;
   assign mem_hit = mem_enable && (offset[15:2] == 14'd0);
   assign commit  = mem_hit && mem_write && (t_cycle == 2'd3);

   assign wr_div  = commit && (offset[1:0] == OFS_DIV);
   assign wr_tima = commit && (offset[1:0] == OFS_TIMA);
   assign wr_tma  = commit && (offset[1:0] == OFS_TMA);
   assign wr_tac  = commit && (offset[1:0] == OFS_TAC);

   always_comb begin
      mem_rdata = 8'hFF;
      if (mem_hit) begin
         case (offset[1:0])
            OFS_DIV:  mem_rdata = divc_q[15:8];
            OFS_TIMA: mem_rdata = tima_q;
            OFS_TMA:  mem_rdata = tma_q;
            default:  mem_rdata = {5'b11111, tac_q};
         endcase
      end
   end

   always_comb begin
      tap_bit = 1'b0;
      case (tac_q[1:0])
         2'b00:   tap_bit = divc_q[9];
         2'b01:   tap_bit = divc_q[3];
         2'b10:   tap_bit = divc_q[5];
         default: tap_bit = divc_q[7];
      endcase
   end

   // DIV and TAC writes drop tick through the registers, so their falling
   // edges are caught by the same detector as ordinary counter edges.
   assign tick    = tac_q[2] & tap_bit;
   assign inc_evt = tick_q & ~tick;

   always_comb begin
      divc_d  = wr_div ? '0 : divc_q + 16'd1;
      tma_d   = wr_tma ? mem_wdata : tma_q;
      tac_d   = wr_tac ? mem_wdata[2:0] : tac_q;
      tima_d  = tima_q;
      state_d = state_q;
      dly_d   = dly_q;
      irq_d   = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (wr_tima) begin
               tima_d = mem_wdata;
            end else if (inc_evt) begin
               if (tima_q == 8'hFF) begin
                  tima_d  = '0;
                  state_d = ST_OVF;
                  dly_d   = 2'd3;
               end else begin
                  tima_d = tima_q + 8'd1;
               end
            end
         end

         ST_OVF: begin
            if (wr_tima) begin
               tima_d  = mem_wdata;
               state_d = ST_RUN;
               dly_d   = '0;
            end else if (dly_q == 2'd0) begin
               tima_d  = tma_q;
               irq_d   = 1'b1;
               state_d = ST_RELOAD;
               dly_d   = 2'd3;
            end else begin
               dly_d = dly_q - 2'd1;
            end
         end

         ST_RELOAD: begin
            // TIMA is locked to TMA here; direct TIMA writes are ignored.
            if (wr_tma) begin
               tima_d = mem_wdata;
            end
            if (dly_q == 2'd0) begin
               state_d = ST_RUN;
            end else begin
               dly_d = dly_q - 2'd1;
            end
         end

         default: begin
            state_d = ST_RUN;
            dly_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         divc_q  <= '0;
         tima_q  <= '0;
         tma_q   <= '0;
         tac_q   <= '0;
         tick_q  <= 1'b0;
         state_q <= ST_RUN;
         dly_q   <= '0;
         irq_q   <= 1'b0;
      end else begin
         divc_q  <= divc_d;
         tima_q  <= tima_d;
         tma_q   <= tma_d;
         tac_q   <= tac_d;
         tick_q  <= tick;
         state_q <= state_d;
         dly_q   <= dly_d;
         irq_q   <= irq_d;
      end
   end

   assign irq_timer = irq_q;

endmodule
